// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the
// state encoding of the register-file dump walker.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/mips_regfile_dump.sv
// Walks the register file through one read port and streams
// (index, data) words out, accumulating an XOR checksum.
module mips_regfile_dump
  import mips_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST =
    (SKIP_ZERO != 0) ? ADDR_W'(1) : '0;

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cs_q, cs_d;
  logic              hs;

  assign hs        = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign checksum  = cs_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cs_d    = cs_q;
    rd_addr = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST;
          cs_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd_addr = idx_q;
        busy    = 1'b1;
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          data_d  = rd_data;
          addr_d  = idx_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        rd_addr = idx_q;
        busy    = 1'b1;
        // abort beats a same-cycle handshake
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (hs) begin
          cs_d    = cs_q ^ data_q;
          valid_d = 1'b0;
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
    end
  end

endmodule

// File: tb/tb_mips_regfile_dump.sv
// Directed bench for mips_regfile_dump: full and
// skip-zero walkers over a modelled register file.
module tb_mips_regfile_dump;

  typedef struct {
    bit          skip;
    int          pat;
    int          stall_word;
    int          stall_cyc;
    int          start_word;
    int          exp_first;
    int          exp_words;
    int          exp_cycles;
    logic [31:0] exp_cs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, abort, out_ready;
  logic [4:0]  rd_addr0, rd_addr1, oaddr0, oaddr1;
  logic [31:0] rd_data0, rd_data1, odata0, odata1;
  logic [31:0] cs0, cs1;
  logic        ov0, ov1, busy0, busy1, done0, done1;
  logic        sel;
  logic [31:0] regs [32];

  logic        s_valid, s_busy, s_done;
  logic [4:0]  s_addr, s_rd;
  logic [31:0] s_data, s_cs;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

  assign s_valid = sel ? ov1    : ov0;
  assign s_busy  = sel ? busy1  : busy0;
  assign s_done  = sel ? done1  : done0;
  assign s_addr  = sel ? oaddr1 : oaddr0;
  assign s_data  = sel ? odata1 : odata0;
  assign s_cs    = sel ? cs1    : cs0;
  assign s_rd    = sel ? rd_addr1 : rd_addr0;

  mips_regfile_dump #(.SKIP_ZERO(0)) u_full (
    .clk(clk), .rst_n(rst_n),
    .start(start0), .abort(abort),
    .rd_addr(rd_addr0), .rd_data(rd_data0),
    .out_valid(ov0), .out_ready(out_ready),
    .out_addr(oaddr0), .out_data(odata0),
    .busy(busy0), .done(done0), .checksum(cs0)
  );

  mips_regfile_dump #(.SKIP_ZERO(1)) u_skip (
    .clk(clk), .rst_n(rst_n),
    .start(start1), .abort(abort),
    .rd_addr(rd_addr1), .rd_data(rd_data1),
    .out_valid(ov1), .out_ready(out_ready),
    .out_addr(oaddr1), .out_data(odata1),
    .busy(busy1), .done(done1), .checksum(cs1)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic load(input int pat);
    for (int i = 0; i < 32; i++)
      regs[i] = (pat != 0) ? (32'h1 << i)
                           : (32'h1000_0000 + i);
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic kick();
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
  endtask

  task automatic wait_word(input int a);
    int n = 0;
    out_ready = 1'b1;
    while (!(s_valid && s_addr == 5'(a)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_word_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int          idx, words, cyc, first, first_cyc, stl;
    logic [31:0] cs;
    bit          fin, sent;
    sel       = v.skip;
    load(v.pat);
    out_ready = 1'b1;
    kick();
    chk("busy_in_fetch", 32'(s_busy), 32'd1);
    chk("valid_in_fetch", 32'(s_valid), 32'd0);
    idx   = v.skip ? 1 : 0;
    words = 0; cyc = 0; first = -1; first_cyc = -1;
    stl   = v.stall_cyc; cs = '0; fin = 0; sent = 0;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      set_start(1'b0);
      if (s_done) begin
        fin = 1;
      end else if (s_valid) begin
        if (first < 0) begin
          first = int'(s_addr);
          first_cyc = cyc;
        end
        if (v.start_word == idx && !sent) begin
          set_start(1'b1);
          sent = 1;
        end
        chk("word_addr", 32'(s_addr), 32'(idx));
        chk("word_data", s_data, regs[idx]);
        if (idx == v.stall_word && stl > 0) begin
          out_ready = 1'b0;
          stl--;
        end else begin
          out_ready = 1'b1;
          cs ^= s_data;
          words++;
          idx++;
        end
      end
    end
    chk("done_seen", 32'(fin), 32'd1);
    chk("first_latency", 32'(first_cyc), 32'd1);
    chk("first_addr", 32'(first), 32'(v.exp_first));
    chk("word_count", 32'(words), 32'(v.exp_words));
    chk("dump_cycles", 32'(cyc), 32'(v.exp_cycles));
    chk("consumer_xor", cs, v.exp_cs);
    chk("checksum", s_cs, v.exp_cs);
    @(negedge clk);
    chk("done_one_cycle", 32'(s_done), 32'd0);
    chk("busy_after", 32'(s_busy), 32'd0);
    chk("checksum_held", s_cs, v.exp_cs);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0, 0, -1, 0, -1, 0, 32, 64, 32'h0000_0000};
    vecs[1] = '{1, 0, -1, 0, -1, 1, 31, 62, 32'h1000_0000};
    vecs[2] = '{0, 1,  3, 5, -1, 0, 32, 69, 32'hFFFF_FFFF};
    vecs[3] = '{0, 1, -1, 0,  5, 0, 32, 64, 32'hFFFF_FFFF};
    vecs[4] = '{1, 1, -1, 0, -1, 1, 31, 62, 32'hFFFF_FFFE};

    rst_n = 1'b0; start0 = 0; start1 = 0;
    abort = 0; out_ready = 1'b1; sel = 0;
    load(0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_cs", cs0, 32'd0);
    chk("rst_data", odata0, 32'd0);
    chk("rst_rdaddr", 32'(rd_addr0), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // abort together with a handshake on word 10
    sel = 0; load(0);
    kick();
    wait_word(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(s_valid), 32'd0);
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_cs", s_cs, 32'h0000_0001);
    chk("abort_rdaddr", 32'(s_rd), 32'd0);
    begin
      logic dn = s_done;
      repeat (3) begin
        @(negedge clk);
        dn |= s_done;
      end
      chk("abort_no_done", 32'(dn), 32'd0);
    end

    // write into reg 2 during its FETCH cycle
    sel = 0; load(0);
    kick();
    wait_word(1);
    @(negedge clk);
    chk("wr_in_fetch", 32'(s_busy && !s_valid), 32'd1);
    regs[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("wr_addr", 32'(s_addr), 32'd2);
    chk("wr_data", s_data, 32'hFFFF_FFFF);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // asynchronous reset while holding word 4
    sel = 0; load(1);
    kick();
    wait_word(4);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_addr", 32'(s_addr), 32'd4);
    chk("pre_rst_cs", s_cs, 32'h0000_000F);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(s_valid), 32'd0);
    chk("arst_addr", 32'(s_addr), 32'd0);
    chk("arst_data", s_data, 32'd0);
    chk("arst_busy", 32'(s_busy), 32'd0);
    chk("arst_cs", s_cs, 32'd0);
    chk("arst_rdaddr", 32'(s_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(s_busy), 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
